// File: rtl/ls_pkg.sv
// Shared size codes and FSM state encoding for the load/store size unit.
package ls_pkg;

  localparam logic [1:0] LS_RSVD = 2'b00;
  localparam logic [1:0] LS_BYTE = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;
  localparam logic [1:0] LS_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ls_state_e;

endpackage

// File: rtl/ls_lane_align.sv
// Combinational lane extract/extend for loads and lane merge for sub-word stores.
// Define LS_BIG_ENDIAN_EN to mirror the byte-lane numbering within a word.
module ls_lane_align
  import ls_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  logic [1:0]        size_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merge_data_o
);

  localparam int unsigned SH_W = $clog2(DATA_W) + 1;

  logic [SH_W-1:0]   lane_byte;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  // lane_byte is the byte position holding the least-significant bits of the lane
  always_comb begin
    lane_byte = '0;
`ifdef LS_BIG_ENDIAN_EN
    case (size_i)
      LS_BYTE: lane_byte = SH_W'(NB - 1) - SH_W'(offset_i);
      LS_HALF: lane_byte = SH_W'(NB - 2) - SH_W'(offset_i);
      default: lane_byte = '0;
    endcase
`else
    if (size_i != LS_WORD) lane_byte = SH_W'(offset_i);
`endif
  end

  always_comb begin
    shamt     = lane_byte << 3;
    shifted   = rdata_i >> shamt;
    lane_mask = '1;
    sign_bit  = 1'b0;
    case (size_i)
      LS_BYTE: begin
        lane_mask = DATA_W'(8'hFF);
        sign_bit  = shifted[7];
      end
      LS_HALF: begin
        lane_mask = DATA_W'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      default: begin
        lane_mask = '1;
        sign_bit  = 1'b0;
      end
    endcase
    load_data_o = shifted & lane_mask;
    if (is_signed_i && sign_bit) load_data_o = load_data_o | ~lane_mask;
    merge_data_o = (rdata_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);
  end

endmodule

// File: rtl/ls_size_unit.sv
// Load/store size unit: alignment trap, sub-word read-modify-write, req/ack memory port.
// Lane ordering selectable with LS_BIG_ENDIAN_EN (see ls_lane_align).
module ls_size_unit
  import ls_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_misalign
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  ls_state_e         state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_misalign_q, rsp_misalign_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [OFF_W-1:0]  req_off;
  logic              misalign;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  ls_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i      (size_q),
    .offset_i    (offset_q),
    .is_signed_i (signed_q),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merge_data_o(merge_data)
  );

  always_comb begin
    req_off  = req_addr[OFF_W-1:0];
    misalign = (req_size == LS_RSVD)
            || ((req_size == LS_HALF) && req_off[0])
            || ((req_size == LS_WORD) && (req_off != '0));
  end

  always_comb begin
    state_d        = state_q;
    store_d        = store_q;
    size_d         = size_q;
    signed_d       = signed_q;
    offset_d       = offset_q;
    wdata_d        = wdata_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rsp_valid_d    = 1'b0;
    rsp_misalign_d = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d    = req_store;
          size_d     = req_size;
          signed_d   = req_signed;
          offset_d   = req_off;
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          if (misalign) begin
            state_d        = ST_DONE;
            rsp_valid_d    = 1'b1;
            rsp_misalign_d = 1'b1;
          end else if (req_store && (req_size == LS_WORD)) begin
            state_d     = ST_WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d   = ST_READ;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          if (store_q) begin
            // mem_req stays high: the write follows the read without a gap
            state_d     = ST_WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = merge_data;
          end else begin
            state_d     = ST_DONE;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_d     = ST_DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      store_q        <= 1'b0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      offset_q       <= '0;
      wdata_q        <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_misalign_q <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      store_q        <= store_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      offset_q       <= offset_d;
      wdata_q        <= wdata_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_misalign_q <= rsp_misalign_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_misalign = rsp_misalign_q;
  assign rsp_rdata    = rsp_rdata_q;

endmodule
